systolic_os_engine: RTL and testbench



---
 rtl/systolic_os_engine.sv | 199 +++++++++++++++++++
 tb/tb_systolic_os_engine.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_os_engine.sv
// Output-stationary N x N systolic matrix multiplier: C = A x B.
// A rows enter from the left and B columns from the top, each skewed so that
// A[i][k] and B[k][j] meet in PE(i,j). Results drain one row per handshake.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start
// FEED   | accepting k-slices; idle cycles inject zero operands
// FLUSH  | 3N-2 zero cycles so the last slice reaches PE(N-1,N-1)
// DRAIN  | presenting result rows 0..N-1 on the output handshake
module systolic_os_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int N          = 4,
  parameter int KW         = 8,
  parameter int SIGNED     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KW-1:0]             k_len,
  output logic                      busy,
  output logic                      done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*DATA_WIDTH-1:0]   a_data,
  input  logic [N*DATA_WIDTH-1:0]   b_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N*ACC_WIDTH-1:0]    out_data,
  output logic [$clog2(N)-1:0]      out_row,
  output logic                      out_last
);
  localparam int RW = $clog2(N);
  localparam int FW = $clog2(3*N-2);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(3*N-3);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_t;
  state_t state, state_nx;

  logic [KW-1:0] k_len_q, beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic [RW-1:0] row_q;
  logic          done_q;

  logic start_acc, beat, last_beat, row_hs, last_row, acc_en, clr;

  logic [DATA_WIDTH-1:0] a_feed [N];
  logic [DATA_WIDTH-1:0] b_feed [N];
  logic [DATA_WIDTH-1:0] a_head [N];
  logic [DATA_WIDTH-1:0] b_head [N];
  logic [DATA_WIDTH-1:0] a_sk   [N][N-1];
  logic [DATA_WIDTH-1:0] b_sk   [N][N-1];
  logic [DATA_WIDTH-1:0] a_in   [N][N];
  logic [DATA_WIDTH-1:0] b_in   [N][N];
  logic [DATA_WIDTH-1:0] a_pe   [N][N];
  logic [DATA_WIDTH-1:0] b_pe   [N][N];
  logic [ACC_WIDTH-1:0]  prod_ext [N][N];
  logic [ACC_WIDTH-1:0]  acc    [N][N];

  // done_q blocks a start in the done cycle even though state is already IDLE
  assign start_acc = (state == S_IDLE) && start && !done_q;
  assign beat      = (state == S_FEED) && in_valid;
  assign last_beat = beat && (beat_cnt == k_len_q - KW'(1));
  assign row_hs    = (state == S_DRAIN) && out_ready;
  assign last_row  = (row_q == RW'(N-1));
  assign acc_en    = (state == S_FEED) || (state == S_FLUSH);
  assign clr       = rst || start_acc;

  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign in_ready  = (state == S_FEED);
  assign out_valid = (state == S_DRAIN);
  assign out_row   = row_q;
  assign out_last  = out_valid && last_row;

  // Edge operands: zero on any cycle without a beat
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_feed[i] = beat ? a_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      b_feed[i] = beat ? b_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end

  // Result row mux, forced to zero outside DRAIN
  always_comb begin
    out_data = '0;
    for (int j = 0; j < N; j++)
      out_data[j*ACC_WIDTH +: ACC_WIDTH] = out_valid ? acc[row_q][j] : '0;
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_head
      if (gi == 0) begin : g_direct
        assign a_head[gi] = a_feed[gi];
        assign b_head[gi] = b_feed[gi];
      end else begin : g_skew
        assign a_head[gi] = a_sk[gi][gi-1];
        assign b_head[gi] = b_sk[gi][gi-1];
      end
    end
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        if (gj == 0) begin : g_aleft
          assign a_in[gi][gj] = a_head[gi];
        end else begin : g_apass
          assign a_in[gi][gj] = a_pe[gi][gj-1];
        end
        if (gi == 0) begin : g_btop
          assign b_in[gi][gj] = b_head[gj];
        end else begin : g_bpass
          assign b_in[gi][gj] = b_pe[gi-1][gj];
        end
        if (SIGNED != 0) begin : g_smul
          logic signed [2*DATA_WIDTH-1:0] p;
          assign p = $signed(a_in[gi][gj]) * $signed(b_in[gi][gj]);
          assign prod_ext[gi][gj] = ACC_WIDTH'(p);
        end else begin : g_umul
          logic [2*DATA_WIDTH-1:0] p;
          assign p = a_in[gi][gj] * b_in[gi][gj];
          assign prod_ext[gi][gj] = ACC_WIDTH'(p);
        end
      end
    end
  endgenerate

  // Skew lines, PE forwarding registers and accumulators
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        for (int s = 0; s < N-1; s++) begin
          a_sk[i][s] <= '0;
          b_sk[i][s] <= '0;
        end
        for (int j = 0; j < N; j++) begin
          a_pe[i][j] <= '0;
          b_pe[i][j] <= '0;
          acc[i][j]  <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        a_sk[i][0] <= a_feed[i];
        b_sk[i][0] <= b_feed[i];
        for (int s = 1; s < N-1; s++) begin
          a_sk[i][s] <= a_sk[i][s-1];
          b_sk[i][s] <= b_sk[i][s-1];
        end
        for (int j = 0; j < N; j++) begin
          a_pe[i][j] <= a_in[i][j];
          b_pe[i][j] <= b_in[i][j];
          if (acc_en) acc[i][j] <= acc[i][j] + prod_ext[i][j];
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_acc) state_nx = (k_len == '0) ? S_DRAIN : S_FEED;
      S_FEED:  if (last_beat) state_nx = S_FLUSH;
      S_FLUSH: if (flush_cnt == '0) state_nx = S_DRAIN;
      S_DRAIN: if (row_hs && last_row) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Job counters and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      k_len_q   <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= row_hs && last_row;
      if (start_acc) begin
        k_len_q  <= k_len;
        beat_cnt <= '0;
        row_q    <= '0;
      end
      if (beat) beat_cnt <= beat_cnt + KW'(1);
      if (last_beat) flush_cnt <= FLUSH_LOAD;
      else if ((state == S_FLUSH) && (flush_cnt != '0)) flush_cnt <= flush_cnt - FW'(1);
      if (row_hs) row_q <= last_row ? '0 : row_q + RW'(1);
    end
  end

endmodule

// File: tb/tb_systolic_os_engine.sv
// Directed bench for systolic_os_engine: a signed and an unsigned instance
// receive identical stimulus; each scenario task checks its own results.
module tb_systolic_os_engine;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int KW = 8;

  logic            clk, rst, start, in_valid, out_ready;
  logic [KW-1:0]   k_len;
  logic [N*DW-1:0] a_data, b_data;
  logic            busy, done, in_ready, out_valid, out_last;
  logic [N*AW-1:0] out_data;
  logic [1:0]      out_row;
  logic            busy_u, done_u, in_ready_u, out_valid_u, out_last_u;
  logic [N*AW-1:0] out_data_u;
  logic [1:0]      out_row_u;

  logic [N*DW-1:0] a_vec [256];
  logic [N*DW-1:0] b_vec [256];
  logic [AW-1:0]   exp_s [N][N];
  logic [AW-1:0]   exp_u [N][N];
  int errors = 0;
  int checks = 0;

  systolic_os_engine #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .N(N), .KW(KW), .SIGNED(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last));

  systolic_os_engine #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .N(N), .KW(KW), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy_u), .done(done_u),
    .in_valid(in_valid), .in_ready(in_ready_u), .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
    .out_row(out_row_u), .out_last(out_last_u));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_identity();
    for (int k = 0; k < 256; k++) begin
      a_vec[k] = '0;
      b_vec[k] = '0;
    end
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) begin
        a_vec[k][i*DW +: DW] = (i == k) ? 16'd1 : 16'd0;
        b_vec[k][i*DW +: DW] = 16'(4*k + i + 1);
      end
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        exp_s[r][j] = 32'(4*r + j + 1);
        exp_u[r][j] = 32'(4*r + j + 1);
      end
  endtask

  task automatic set_const(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                           input logic [AW-1:0] es, input logic [AW-1:0] eu);
    for (int k = 0; k < 256; k++) begin
      a_vec[k] = {N{av}};
      b_vec[k] = {N{bv}};
    end
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        exp_s[r][j] = es;
        exp_u[r][j] = eu;
      end
  endtask

  task automatic do_start(input int k);
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
  endtask

  task automatic feed(input int klen, input int mode);
    int idx = 0;
    int cyc = 0;
    while (idx < klen && cyc < 3000) begin
      in_valid = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      a_data = a_vec[idx];
      b_data = b_vec[idx];
      if (in_valid && in_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (idx < klen) begin errors++; $display("FAIL feed_timeout: got %0d beats expected %0d", idx, klen); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL feed_to_flush: in_ready got %b expected 0", in_ready); end
  endtask

  task automatic collect(input int stall_row, input int stall_n, input int exp_lat, input bit restart);
    int row_exp = 0;
    int stalled = 0;
    int cyc = 0;
    int first = -1;
    logic [N*AW-1:0] es, eu;
    while (row_exp < N && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (first < 0) begin
          first = cyc;
          if (exp_lat >= 0) begin
            checks++;
            if (first != exp_lat) begin errors++; $display("FAIL drain_latency: got %0d expected %0d", first, exp_lat); end
          end
        end
        for (int j = 0; j < N; j++) begin
          es[j*AW +: AW] = exp_s[row_exp][j];
          eu[j*AW +: AW] = exp_u[row_exp][j];
        end
        checks++;
        if (out_row !== 2'(row_exp)) begin errors++; $display("FAIL out_row: got %0d expected %0d", out_row, row_exp); end
        checks++;
        if (out_data !== es) begin errors++; $display("FAIL row%0d_signed: got %h expected %h", row_exp, out_data, es); end
        checks++;
        if (out_data_u !== eu) begin errors++; $display("FAIL row%0d_unsigned: got %h expected %h", row_exp, out_data_u, eu); end
        checks++;
        if (out_last !== (row_exp == N-1)) begin errors++; $display("FAIL out_last row%0d: got %b expected %b", row_exp, out_last, row_exp == N-1); end
        if (row_exp == stall_row && stalled < stall_n) begin
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = 1'b1;
          row_exp++;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    checks++;
    if (row_exp < N) begin errors++; $display("FAIL drain_timeout: got %0d rows expected %0d", row_exp, N); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({done, busy, out_valid} !== 3'b100) begin
      errors++; $display("FAIL done_pulse: got done/busy/valid %b%b%b expected 100", done, busy, out_valid);
    end
    if (restart) begin
      start = 1'b1;
      k_len = '0;
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL after_done: got done/busy %b%b expected 00", done, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    k_len = '0; a_data = '0; b_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, in_ready, out_valid, out_last} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b%b%b%b%b expected 00000", busy, done, in_ready, out_valid, out_last);
    end
    checks++;
    if (out_row !== 2'd0) begin errors++; $display("FAIL reset_row: got %0d expected 0", out_row); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
    checks++;
    if ({busy_u, done_u, in_ready_u, out_valid_u, out_last_u, out_row_u} !== 7'b0 || out_data_u !== '0) begin
      errors++; $display("FAIL reset_unsigned: got %b%b%b%b%b %0d expected zeros", busy_u, done_u, in_ready_u, out_valid_u, out_last_u, out_row_u);
    end
    rst = 1'b0;
  endtask

  task automatic test_identity();
    set_identity();
    do_start(4);
    feed(4, 0);
    collect(-1, 0, 10, 1'b0);
  endtask

  task automatic test_k_zero();
    set_const(16'd5, 16'd7, 32'd0, 32'd0);
    do_start(0);
    checks++;
    if ({in_ready, out_valid} !== 2'b01) begin errors++; $display("FAIL kzero_direct_drain: got ready/valid %b%b expected 01", in_ready, out_valid); end
    collect(-1, 0, -1, 1'b0);
  endtask

  task automatic test_bubbles();
    set_identity();
    do_start(4);
    start = 1'b1;
    k_len = '0;
    feed(4, 1);
    start = 1'b0;
    collect(-1, 0, 10, 1'b0);
  endtask

  task automatic test_stall();
    set_identity();
    do_start(4);
    feed(4, 0);
    in_valid = 1'b1;
    a_data = {N{16'h7777}};
    b_data = {N{16'h1234}};
    collect(2, 5, 10, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic test_signed();
    set_const(16'hFFFF, 16'h7FFF, 32'hFFFE8003, 32'h7FFB8003);
    do_start(3);
    feed(3, 0);
    collect(-1, 0, 10, 1'b0);
  endtask

  task automatic test_wrap();
    set_const(16'hFFFF, 16'hFFFF, 32'd255, 32'hFE0200FF);
    do_start(255);
    feed(255, 0);
    collect(-1, 0, 10, 1'b0);
  endtask

  task automatic test_reset_flush();
    bit leak = 1'b0;
    set_identity();
    do_start(4);
    feed(4, 0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy: got %b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, in_ready, out_valid} !== 4'b0) begin
      errors++; $display("FAIL abort_ctrl: got %b%b%b%b expected 0000", busy, done, in_ready, out_valid);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid || done) leak = 1'b1;
    end
    checks++;
    if (leak) begin errors++; $display("FAIL abort_output: got leaked row/done expected none"); end
    for (int k = 0; k < 256; k++) begin
      a_vec[k] = '0;
      b_vec[k] = '0;
    end
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        a_vec[k][i*DW +: DW] = 16'(i + 1);
        b_vec[k][i*DW +: DW] = 16'(i + 1);
      end
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        exp_s[r][j] = 32'(2*(r+1)*(j+1));
        exp_u[r][j] = 32'(2*(r+1)*(j+1));
      end
    do_start(2);
    feed(2, 0);
    collect(-1, 0, 10, 1'b0);
  endtask

  task automatic test_done_start();
    set_identity();
    do_start(4);
    feed(4, 0);
    collect(-1, 0, 10, 1'b1);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, out_valid} !== 2'b11) begin errors++; $display("FAIL late_start: got busy/valid %b%b expected 11", busy, out_valid); end
    set_const(16'd0, 16'd0, 32'd0, 32'd0);
    collect(-1, 0, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_k_zero();
    test_bubbles();
    test_stall();
    test_signed();
    test_wrap();
    test_reset_flush();
    test_done_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
